// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@72 timing constants, line size and scheduler state type
package vga_pkg;
  localparam int HOR_FIELD      = 799;
  localparam int HOR_TOTAL      = 1042;
  localparam int VER_FIELD      = 599;
  localparam int VER_TOTAL      = 665;
  localparam int WORDS_PER_LINE = 200;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fb_sched_state_t;
endpackage

// File: rtl/vga_fb_scheduler_if.sv
// vga_fb_scheduler_if: timing, draw-write, framebuffer and line-buffer signals of the scheduler
// master: scheduler side (drives wr_ready, mem_*, lb_*, underrun*); slave: surrounding system
interface vga_fb_scheduler_if #(parameter int ADDR_W = 16, parameter int DATA_W = 32);
  logic [11:0]       display_col;
  logic [10:0]       display_row;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              lb_we;
  logic              lb_bank;
  logic [7:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic              underrun;
  logic              underrun_pulse;
  modport master (
    input  display_col, display_row, wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_req, mem_we, mem_addr, mem_wdata,
           lb_we, lb_bank, lb_addr, lb_wdata, underrun, underrun_pulse
  );
  modport slave (
    output display_col, display_row, wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_req, mem_we, mem_addr, mem_wdata,
           lb_we, lb_bank, lb_addr, lb_wdata, underrun, underrun_pulse
  );
endinterface

// File: rtl/vga_fb_rd_pipe.sv
// vga_fb_rd_pipe: RD_LATENCY-deep valid/index delay line turning read strobes into line-buffer writes
// i_valid/i_idx: read strobe and its word index; i_rdata: framebuffer read data
// o_we/o_addr/o_wdata: registered line-buffer write; o_busy: a read is still in flight
module vga_fb_rd_pipe #(parameter int RD_LATENCY = 2, parameter int DATA_W = 32) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [7:0]        i_idx,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy,
  output logic              o_we,
  output logic [7:0]        o_addr,
  output logic [DATA_W-1:0] o_wdata
);
  logic [RD_LATENCY-1:0]      r_v;
  logic [RD_LATENCY-1:0][7:0] r_idx;
  logic                       r_we;
  logic [7:0]                 r_addr;
  logic [DATA_W-1:0]          r_wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v     <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_v[0]   <= i_valid;
      r_idx[0] <= i_idx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_v[k]   <= r_v[k-1];
        r_idx[k] <= r_idx[k-1];
      end
      // the last stage lines up with the cycle mem_rdata is valid
      r_we <= r_v[RD_LATENCY-1];
      if (r_v[RD_LATENCY-1]) begin
        r_addr  <= r_idx[RD_LATENCY-1];
        r_wdata <= i_rdata;
      end
    end
  end
  assign o_busy  = |r_v;
  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
endmodule

// File: rtl/vga_fb_scheduler.sv
// vga_fb_scheduler: shares one framebuffer port between per-line display prefetch and draw writes
// clock/reset: system clock, synchronous active-high reset
// fb (master): timing position and draw handshake in; framebuffer strobes, line-buffer writes,
//              and deadline-miss flags out
module vga_fb_scheduler #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
  parameter int HOR_FIELD      = vga_pkg::HOR_FIELD,
  parameter int HOR_TOTAL      = vga_pkg::HOR_TOTAL,
  parameter int VER_FIELD      = vga_pkg::VER_FIELD,
  parameter int VER_TOTAL      = vga_pkg::VER_TOTAL,
  parameter int RD_LATENCY     = 2
) (
  input logic             clock,
  input logic             reset,
  vga_fb_scheduler_if.master fb
);
  import vga_pkg::*;
  fb_sched_state_t   r_state;
  logic [7:0]        r_idx;
  logic [7:0]        r_mem_idx;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_bank;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_underrun;
  logic              r_pulse;
  logic              r_miss_d;
  logic              w_trig;
  logic              w_miss;
  logic              w_pipe_busy;
  assign w_trig = fb.display_col == 12'(HOR_FIELD) &&
                  (fb.display_row < 11'(VER_FIELD) || fb.display_row == 11'(VER_TOTAL));
  // a deadline column held for several cycles still counts as a single miss
  assign w_miss = fb.display_col == 12'(HOR_TOTAL) && r_state != IDLE;
  assign fb.wr_ready = !reset && r_state == IDLE && !w_trig;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_mem_idx   <= '0;
      r_line_base <= '0;
      r_bank      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_underrun  <= 1'b0;
      r_pulse     <= 1'b0;
      r_miss_d    <= 1'b0;
    end else begin
      r_miss_d   <= w_miss;
      r_pulse    <= w_miss && !r_miss_d;
      r_underrun <= r_underrun || w_miss;
      r_mem_req  <= 1'b0;
      case (r_state)
        IDLE:
          if (w_trig) begin
            r_bank      <= !r_bank;
            r_idx       <= '0;
            r_line_base <= fb.display_row == 11'(VER_TOTAL) ? '0 : r_line_base + ADDR_W'(WORDS_PER_LINE);
            r_state     <= FETCH;
          end else if (fb.wr_valid) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= fb.wr_addr;
            r_mem_wdata <= fb.wr_data;
          end
        FETCH: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_line_base + ADDR_W'(r_idx);
          r_mem_idx  <= r_idx;
          r_idx      <= r_idx + 8'd1;
          if (r_idx == 8'(WORDS_PER_LINE - 1)) r_state <= DRAIN;
        end
        DRAIN:
          // the last strobe is still on the bus in the first DRAIN cycle
          if (!r_mem_req && !w_pipe_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  vga_fb_rd_pipe #(.RD_LATENCY(RD_LATENCY), .DATA_W(DATA_W)) u_rd_pipe (
    .clock   (clock),
    .reset   (reset),
    .i_valid (r_mem_req && !r_mem_we),
    .i_idx   (r_mem_idx),
    .i_rdata (fb.mem_rdata),
    .o_busy  (w_pipe_busy),
    .o_we    (fb.lb_we),
    .o_addr  (fb.lb_addr),
    .o_wdata (fb.lb_wdata)
  );
  assign fb.mem_req        = r_mem_req;
  assign fb.mem_we         = r_mem_we;
  assign fb.mem_addr       = r_mem_addr;
  assign fb.mem_wdata      = r_mem_wdata;
  assign fb.lb_bank        = r_bank;
  assign fb.underrun       = r_underrun;
  assign fb.underrun_pulse = r_pulse;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb_vga_fb_scheduler: directed/randomized bench with a framebuffer ROM and a line-level reference model
module tb_vga_fb_scheduler;
  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic        bk;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] salt = 32'h0;
  logic [31:0] pa[2];
  logic [31:0] pb[60];
  ev_t  rd_q[$], wr_q[$], lb_q[$], hs_q[$];
  int   a_pulses = 0, b_pulses = 0, b_lb = 0;
  logic [15:0] ea[10];
  logic [31:0] ed[10];

  vga_fb_scheduler_if #(.ADDR_W(16), .DATA_W(32)) a_if ();
  vga_fb_scheduler_if #(.ADDR_W(16), .DATA_W(32)) b_if ();

  vga_fb_scheduler dut_a (.clock(clock), .reset(reset), .fb(a_if));
  vga_fb_scheduler #(.RD_LATENCY(60)) dut_b (.clock(clock), .reset(reset), .fb(b_if));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // framebuffer contents: a fixed per-run pseudo-random word for each address
  function automatic logic [31:0] ram_rd(input logic [15:0] ad);
    return ({16'h0, ad} * 32'h9E37_79B1) ^ salt;
  endfunction

  // read data becomes valid RD_LATENCY cycles after the strobe cycle
  always @(posedge clock) begin
    pa[0] <= ram_rd(a_if.mem_addr);
    pa[1] <= pa[0];
    pb[0] <= ram_rd(b_if.mem_addr);
    for (int k = 1; k < 60; k++) pb[k] <= pb[k-1];
  end
  assign a_if.mem_rdata = pa[1];
  assign b_if.mem_rdata = pb[59];

  always @(negedge clock) begin
    if (a_if.mem_req && !a_if.mem_we) rd_q.push_back(ev_t'{cyc, 32'(a_if.mem_addr), ram_rd(a_if.mem_addr), 1'b0});
    if (a_if.mem_req && a_if.mem_we) wr_q.push_back(ev_t'{cyc, 32'(a_if.mem_addr), a_if.mem_wdata, 1'b0});
    if (a_if.lb_we) lb_q.push_back(ev_t'{cyc, 32'(a_if.lb_addr), a_if.lb_wdata, a_if.lb_bank});
    if (a_if.wr_valid && a_if.wr_ready) hs_q.push_back(ev_t'{cyc, 32'(a_if.wr_addr), a_if.wr_data, 1'b0});
    if (a_if.underrun_pulse) a_pulses++;
    if (b_if.underrun_pulse) b_pulses++;
    if (b_if.lb_we) b_lb++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_pos(input int c, input int r);
    a_if.display_col = 12'(c);
    a_if.display_row = 11'(r);
  endtask

  task automatic trigger(input int r);
    set_pos(798, r);
    step(1);
    set_pos(799, r);
    step(1);
    set_pos(800, r);
  endtask

  task automatic wait_lb(input int n, input int budget);
    int i = 0;
    while (lb_q.size() < n && i < budget) begin
      step(1);
      i++;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_req"}, a_if.mem_req, 0);
    chk({tag, "_mem_we"}, a_if.mem_we, 0);
    chk({tag, "_mem_addr"}, a_if.mem_addr, 0);
    chk({tag, "_lb_we"}, a_if.lb_we, 0);
    chk({tag, "_lb_bank"}, a_if.lb_bank, 0);
    chk({tag, "_lb_addr"}, a_if.lb_addr, 0);
    chk({tag, "_wr_ready"}, a_if.wr_ready, 0);
    chk({tag, "_underrun"}, a_if.underrun, 0);
    chk({tag, "_underrun_pulse"}, a_if.underrun_pulse, 0);
  endtask

  // one fetch = 200 reads at base+k on consecutive cycles, and 200 line-buffer writes
  // of index k carrying that read's data, RD_LATENCY+1 cycles later, into the new bank
  task automatic check_fetch(input string tag, input int rd0, input int lb0,
                             input logic [15:0] base, input logic bank);
    int n, ba, bg, bl, bt, bb;
    logic [15:0] ex;
    wait_lb(lb0 + 200, 600);
    step(5);
    chk({tag, "_rd_count"}, rd_q.size() - rd0, 200);
    chk({tag, "_lb_count"}, lb_q.size() - lb0, 200);
    n = rd_q.size() - rd0;
    if (lb_q.size() - lb0 < n) n = lb_q.size() - lb0;
    if (n > 200) n = 200;
    ba = 0; bg = 0; bl = 0; bt = 0; bb = 0;
    for (int k = 0; k < n; k++) begin
      ex = base + 16'(k);
      if (rd_q[rd0+k].a !== {16'h0, ex}) ba++;
      if (k > 0 && rd_q[rd0+k].cyc != rd_q[rd0+k-1].cyc + 1) bg++;
      if (lb_q[lb0+k].a !== 32'(k) || lb_q[lb0+k].d !== rd_q[rd0+k].d) bl++;
      if (lb_q[lb0+k].cyc != rd_q[rd0+k].cyc + 3) bt++;
      if (lb_q[lb0+k].bk !== bank) bb++;
    end
    chk({tag, "_rd_addr_errs"}, ba, 0);
    chk({tag, "_rd_gap_errs"}, bg, 0);
    chk({tag, "_lb_data_errs"}, bl, 0);
    chk({tag, "_lb_latency_errs"}, bt, 0);
    chk({tag, "_lb_bank_errs"}, bb, 0);
    chk({tag, "_bank_now"}, a_if.lb_bank, bank);
    chk({tag, "_first_rd_addr"}, rd_q.size() > rd0 ? rd_q[rd0].a : 32'hFFFF_FFFF, {16'h0, base});
  endtask

  initial begin
    int rd0, lb0, hs0, wr0, c0, r, i, bad, bl0;
    logic [15:0] exp_base;
    logic exp_bank;
    salt = $urandom;
    set_pos(0, 0);
    a_if.wr_valid = 1'b0;
    a_if.wr_addr = '0;
    a_if.wr_data = '0;
    b_if.display_col = '0;
    b_if.display_row = '0;
    b_if.wr_valid = 1'b0;
    b_if.wr_addr = '0;
    b_if.wr_data = '0;
    step(3);
    chk_idle_outputs("reset");
    reset = 1'b0;
    step(1);
    chk("idle_wr_ready", a_if.wr_ready, 1);
    exp_base = 16'h0;
    exp_bank = 1'b0;

    // row 5 fetch straight after reset
    rd0 = rd_q.size(); lb0 = lb_q.size();
    trigger(5);
    exp_base = exp_base + 16'd200; exp_bank = ~exp_bank;
    check_fetch("row5", rd0, lb0, exp_base, exp_bank);

    // random visible row
    r = $urandom_range(0, 598);
    rd0 = rd_q.size(); lb0 = lb_q.size();
    trigger(r);
    exp_base = exp_base + 16'd200; exp_bank = ~exp_bank;
    check_fetch("rowrand", rd0, lb0, exp_base, exp_bank);

    // last frame row prefetches row 0 from address 0, then row 0 prefetches row 1
    rd0 = rd_q.size(); lb0 = lb_q.size();
    trigger(665);
    exp_base = 16'h0; exp_bank = ~exp_bank;
    check_fetch("row665", rd0, lb0, exp_base, exp_bank);
    rd0 = rd_q.size(); lb0 = lb_q.size();
    trigger(0);
    exp_base = exp_base + 16'd200; exp_bank = ~exp_bank;
    check_fetch("row0", rd0, lb0, exp_base, exp_bank);

    // vertical blanking rows never fetch
    rd0 = rd_q.size();
    trigger(599);
    step(10);
    trigger($urandom_range(600, 664));
    step(10);
    chk("vblank_no_reads", rd_q.size() - rd0, 0);
    chk("vblank_bank", a_if.lb_bank, exp_bank);

    // write held across a trig-coincident fetch is accepted once, after the fetch
    r = $urandom_range(1, 598);
    rd0 = rd_q.size(); lb0 = lb_q.size(); hs0 = hs_q.size(); wr0 = wr_q.size();
    set_pos(798, r);
    step(1);
    set_pos(799, r);
    a_if.wr_valid = 1'b1;
    a_if.wr_addr = 16'h1234;
    a_if.wr_data = 32'hDEAD_BEEF;
    step(1);
    set_pos(800, r);
    i = 0;
    while (hs_q.size() == hs0 && i < 600) begin
      step(1);
      i++;
    end
    a_if.wr_valid = 1'b0;
    exp_base = exp_base + 16'd200; exp_bank = ~exp_bank;
    check_fetch("heldwr", rd0, lb0, exp_base, exp_bank);
    chk("heldwr_handshakes", hs_q.size() - hs0, 1);
    chk("heldwr_mem_writes", wr_q.size() - wr0, 1);
    if (wr_q.size() > wr0 && hs_q.size() > hs0 && rd_q.size() >= rd0 + 200) begin
      chk("heldwr_addr", wr_q[wr0].a, 32'h1234);
      chk("heldwr_data", wr_q[wr0].d, 32'hDEAD_BEEF);
      chk("heldwr_latency", wr_q[wr0].cyc - hs_q[hs0].cyc, 1);
      chk("heldwr_after_drain", hs_q[hs0].cyc > rd_q[rd0+199].cyc + 2, 1);
    end

    // ten back-to-back writes in IDLE
    hs0 = hs_q.size(); wr0 = wr_q.size();
    a_if.wr_valid = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      ea[k] = 16'($urandom_range(32768, 65535));
      ed[k] = $urandom;
      a_if.wr_addr = ea[k];
      a_if.wr_data = ed[k];
      step(1);
    end
    a_if.wr_valid = 1'b0;
    step(3);
    chk("b2b_handshakes", hs_q.size() - hs0, 10);
    chk("b2b_mem_writes", wr_q.size() - wr0, 10);
    bad = 0;
    for (int k = 0; k < 10 && wr0 + k < wr_q.size(); k++)
      if (wr_q[wr0+k].a !== {16'h0, ea[k]} || wr_q[wr0+k].d !== ed[k] || wr_q[wr0+k].cyc != c0 + 1 + k) bad++;
    chk("b2b_write_errs", bad, 0);
    chk("no_underrun_a", a_if.underrun, 0);
    chk("no_underrun_pulses_a", a_pulses, 0);

    // reset in the middle of a fetch
    rd0 = rd_q.size();
    trigger($urandom_range(0, 598));
    i = 0;
    while (rd_q.size() < rd0 + 50 && i < 400) begin
      step(1);
      i++;
    end
    reset = 1'b1;
    step(1);
    chk_idle_outputs("midreset");
    reset = 1'b0;
    lb0 = lb_q.size(); rd0 = rd_q.size();
    step(20);
    chk("midreset_no_lb", lb_q.size() - lb0, 0);
    chk("midreset_no_rd", rd_q.size() - rd0, 0);
    exp_base = 16'h0; exp_bank = 1'b0;
    rd0 = rd_q.size(); lb0 = lb_q.size();
    trigger($urandom_range(0, 598));
    exp_base = exp_base + 16'd200; exp_bank = ~exp_bank;
    check_fetch("postreset", rd0, lb0, exp_base, exp_bank);

    // slow framebuffer: deadline column reached while still draining
    bl0 = b_lb;
    chk("b_underrun_clear", b_if.underrun, 0);
    b_if.display_row = 11'd10;
    b_if.display_col = 12'd799;
    step(1);
    b_if.display_col = 12'd800;
    step(210);
    b_if.display_col = 12'd1042;
    step(20);
    b_if.display_col = 12'd0;
    i = 0;
    while (b_lb < bl0 + 200 && i < 400) begin
      step(1);
      i++;
    end
    step(5);
    chk("b_underrun_pulses", b_pulses, 1);
    chk("b_underrun_sticky", b_if.underrun, 1);
    chk("b_pulse_low", b_if.underrun_pulse, 0);
    chk("b_lb_count", b_lb - bl0, 200);
    chk("a_no_underrun_end", a_if.underrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
